// File: rtl/fft_radix2_bfly.sv
// Radix-2 decimation-in-time butterfly stage.
// Pairs consecutive valid samples as (A, B). The twiddle W is taken with B.
// It computes X0 = A + W*B and X1 = A - W*B through a three-stage pipeline.
// The twiddle is signed Q1.12, so 4096 represents 1.0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clr                 synchronous start-of-stage clear (phase, counter, ovf, in-flight valids)
//   en_radix            input sample valid
//   Re_i, Im_i          signed input sample
//   cos_data, sin_data  signed Q1.12 twiddle, W = cos_data + j*sin_data (table holds -sin)
//   Re_o0, Im_o0        X0 result
//   Re_o1, Im_o1        X1 result
//   out_valid           one-cycle pulse per completed butterfly
//   bfly_idx            index of the butterfly currently on the outputs
//   stage_done          pulse with the out_valid of the last butterfly in a stage
//   ovf                 sticky overflow on output truncation
module fft_radix2_bfly #(
  parameter int unsigned bit_width = 29,
  parameter int unsigned SIZE      = 4,
  parameter int unsigned N         = 16,
  parameter bit          SCALE     = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en_radix,
  input  logic signed [bit_width-1:0] Re_i,
  input  logic signed [bit_width-1:0] Im_i,
  input  logic signed [13:0]          cos_data,
  input  logic signed [13:0]          sin_data,
  output logic signed [bit_width-1:0] Re_o0,
  output logic signed [bit_width-1:0] Im_o0,
  output logic signed [bit_width-1:0] Re_o1,
  output logic signed [bit_width-1:0] Im_o1,
  output logic                        out_valid,
  output logic [SIZE-2:0]             bfly_idx,
  output logic                        stage_done,
  output logic                        ovf
);

  localparam int unsigned PW = bit_width + 14;  // product width
  localparam int unsigned SW = bit_width + 2;   // butterfly sum width
  localparam logic [SIZE-2:0] LastIdx = (SIZE-1)'(N/2 - 1);

  typedef enum logic {StWaitA, StWaitB} phase_e;

  phase_e                      phase_q;
  logic signed [bit_width-1:0] a_re_q, a_im_q;

  // Stage 1: products plus the A that belongs to them
  logic                        v1_q;
  logic signed [PW-1:0]        pcc_q, pss_q, pcs_q, psc_q;
  logic signed [bit_width-1:0] a1_re_q, a1_im_q;

  // Stage 2: rotated B and its A
  logic                        v2_q;
  logic signed [bit_width:0]   wb_re_q, wb_im_q;
  logic signed [bit_width-1:0] a2_re_q, a2_im_q;

  logic [SIZE-2:0]             cnt_q;

  // Stage 2 combinational: difference/sum, then floor shift by 12
  logic signed [PW:0]          re_acc, im_acc;
  logic signed [bit_width:0]   wb_re, wb_im;
  logic                        unused_acc;

  always_comb begin
    re_acc = {pcc_q[PW-1], pcc_q} - {pss_q[PW-1], pss_q};
    im_acc = {pcs_q[PW-1], pcs_q} + {psc_q[PW-1], psc_q};
    // Selecting bits [bw+12:12] is an arithmetic >>> 12 followed by truncation to bw+1 bits
    wb_re  = re_acc[bit_width+12:12];
    wb_im  = im_acc[bit_width+12:12];
  end

  assign unused_acc = ^{re_acc[PW:bit_width+13], im_acc[PW:bit_width+13],
                        re_acc[11:0], im_acc[11:0]};

  // Stage 3 combinational: butterfly sums, optional /2, overflow detect
  logic signed [SW-1:0] s0_re, s0_im, s1_re, s1_im;
  logic                 ovf_hit;

  always_comb begin
    s0_re = {{2{a2_re_q[bit_width-1]}}, a2_re_q} + {wb_re_q[bit_width], wb_re_q};
    s0_im = {{2{a2_im_q[bit_width-1]}}, a2_im_q} + {wb_im_q[bit_width], wb_im_q};
    s1_re = {{2{a2_re_q[bit_width-1]}}, a2_re_q} - {wb_re_q[bit_width], wb_re_q};
    s1_im = {{2{a2_im_q[bit_width-1]}}, a2_im_q} - {wb_im_q[bit_width], wb_im_q};
    if (SCALE) begin
      s0_re = s0_re >>> 1;
      s0_im = s0_im >>> 1;
      s1_re = s1_re >>> 1;
      s1_im = s1_im >>> 1;
    end
    // A value fits in bit_width bits iff its top three bits are all equal
    ovf_hit = !((&s0_re[SW-1:bit_width-1]) || !(|s0_re[SW-1:bit_width-1])) ||
              !((&s0_im[SW-1:bit_width-1]) || !(|s0_im[SW-1:bit_width-1])) ||
              !((&s1_re[SW-1:bit_width-1]) || !(|s1_re[SW-1:bit_width-1])) ||
              !((&s1_im[SW-1:bit_width-1]) || !(|s1_im[SW-1:bit_width-1]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= StWaitA;
      a_re_q     <= '0;
      a_im_q     <= '0;
      v1_q       <= 1'b0;
      pcc_q      <= '0;
      pss_q      <= '0;
      pcs_q      <= '0;
      psc_q      <= '0;
      a1_re_q    <= '0;
      a1_im_q    <= '0;
      v2_q       <= 1'b0;
      wb_re_q    <= '0;
      wb_im_q    <= '0;
      a2_re_q    <= '0;
      a2_im_q    <= '0;
      cnt_q      <= '0;
      Re_o0      <= '0;
      Im_o0      <= '0;
      Re_o1      <= '0;
      Im_o1      <= '0;
      out_valid  <= 1'b0;
      bfly_idx   <= '0;
      stage_done <= 1'b0;
      ovf        <= 1'b0;
    end else if (clr) begin
      // Data registers hold; only control state restarts
      phase_q    <= StWaitA;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      cnt_q      <= '0;
      out_valid  <= 1'b0;
      stage_done <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      v1_q       <= 1'b0;
      out_valid  <= v2_q;
      stage_done <= v2_q && (cnt_q == LastIdx);

      if (en_radix) begin
        if (phase_q == StWaitA) begin
          a_re_q  <= Re_i;
          a_im_q  <= Im_i;
          phase_q <= StWaitB;
        end else begin
          pcc_q   <= PW'(Re_i) * PW'(cos_data);
          pss_q   <= PW'(Im_i) * PW'(sin_data);
          pcs_q   <= PW'(Re_i) * PW'(sin_data);
          psc_q   <= PW'(Im_i) * PW'(cos_data);
          a1_re_q <= a_re_q;
          a1_im_q <= a_im_q;
          v1_q    <= 1'b1;
          phase_q <= StWaitA;
        end
      end

      v2_q <= v1_q;
      if (v1_q) begin
        wb_re_q <= wb_re;
        wb_im_q <= wb_im;
        a2_re_q <= a1_re_q;
        a2_im_q <= a1_im_q;
      end

      if (v2_q) begin
        Re_o0    <= s0_re[bit_width-1:0];
        Im_o0    <= s0_im[bit_width-1:0];
        Re_o1    <= s1_re[bit_width-1:0];
        Im_o1    <= s1_im[bit_width-1:0];
        bfly_idx <= cnt_q;
        cnt_q    <= (cnt_q == LastIdx) ? '0 : cnt_q + 1'b1;
        ovf      <= ovf | ovf_hit;
      end
    end
  end

endmodule

// File: tb/tb_fft_radix2_bfly.sv
// Directed bench for fft_radix2_bfly: an unscaled instance plus a SCALE=1 instance on the
// same stimulus. Inputs change and outputs are sampled on the falling clock edge.
module tb_fft_radix2_bfly;

  logic clk, rst, clr, en_radix;
  logic signed [28:0] Re_i, Im_i;
  logic signed [13:0] cos_data, sin_data;
  logic signed [28:0] Re_o0, Im_o0, Re_o1, Im_o1;
  logic signed [28:0] re0_s, im0_s, re1_s, im1_s;
  logic out_valid, stage_done, ovf, out_valid_s, stage_done_s, ovf_s;
  logic [2:0] bfly_idx, bfly_idx_s;

  int total = 0;
  int bad   = 0;

  fft_radix2_bfly #(.bit_width(29), .SIZE(4), .N(16), .SCALE(1'b0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en_radix(en_radix),
    .Re_i(Re_i), .Im_i(Im_i), .cos_data(cos_data), .sin_data(sin_data),
    .Re_o0(Re_o0), .Im_o0(Im_o0), .Re_o1(Re_o1), .Im_o1(Im_o1),
    .out_valid(out_valid), .bfly_idx(bfly_idx), .stage_done(stage_done), .ovf(ovf)
  );

  fft_radix2_bfly #(.bit_width(29), .SIZE(4), .N(16), .SCALE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .clr(clr), .en_radix(en_radix),
    .Re_i(Re_i), .Im_i(Im_i), .cos_data(cos_data), .sin_data(sin_data),
    .Re_o0(re0_s), .Im_o0(im0_s), .Re_o1(re1_s), .Im_o1(im1_s),
    .out_valid(out_valid_s), .bfly_idx(bfly_idx_s), .stage_done(stage_done_s), .ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic signed [28:0] re, input logic signed [28:0] im,
                      input logic signed [13:0] c, input logic signed [13:0] s);
    en_radix = 1'b1;
    Re_i = re;
    Im_i = im;
    cos_data = c;
    sin_data = s;
    @(negedge clk);
    en_radix = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({Re_o0, Im_o0, Re_o1, Im_o1} !== '0) begin
      bad++;
      $display("FAIL reset_data got (%0d,%0d) (%0d,%0d) want all 0", Re_o0, Im_o0, Re_o1, Im_o1);
    end
    total++;
    if ({out_valid, bfly_idx, stage_done, ovf} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got v=%b idx=%0d sd=%b ovf=%b want 0", out_valid, bfly_idx,
               stage_done, ovf);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_w_one();
    send(29'(100), 29'(50), 14'sd4096, 14'sd0);
    send(29'(30), -29'(20), 14'sd4096, 14'sd0);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL w1_early_valid got %b want 0", out_valid);
    end
    @(negedge clk);
    total++;
    if ({Re_o0, Im_o0, Re_o1, Im_o1} !== {29'(130), 29'(30), 29'(70), 29'(70)}) begin
      bad++;
      $display("FAIL w1_data got (%0d,%0d) (%0d,%0d) want (130,30) (70,70)",
               Re_o0, Im_o0, Re_o1, Im_o1);
    end
    total++;
    if ({out_valid, bfly_idx, stage_done} !== {1'b1, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL w1_ctrl got v=%b idx=%0d sd=%b want v=1 idx=0 sd=0", out_valid, bfly_idx,
               stage_done);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || Re_o0 !== 29'(130)) begin
      bad++;
      $display("FAIL w1_hold got v=%b re0=%0d want v=0 re0=130", out_valid, Re_o0);
    end
  endtask

  task automatic test_w_minus_j();
    send(29'(100), 29'(50), 14'sd0, 14'sd0);
    send(29'(30), -29'(20), 14'sd0, -14'sd4096);
    repeat (2) @(negedge clk);
    total++;
    if ({Re_o0, Im_o0, Re_o1, Im_o1} !== {29'(80), 29'(20), 29'(120), 29'(80)}) begin
      bad++;
      $display("FAIL wmj_data got (%0d,%0d) (%0d,%0d) want (80,20) (120,80)",
               Re_o0, Im_o0, Re_o1, Im_o1);
    end
    total++;
    if ({out_valid, bfly_idx} !== {1'b1, 3'd1}) begin
      bad++;
      $display("FAIL wmj_ctrl got v=%b idx=%0d want v=1 idx=1", out_valid, bfly_idx);
    end
  endtask

  task automatic test_floor();
    send(29'(10), 29'(10), 14'sd0, 14'sd0);
    send(-29'(1), 29'(0), 14'sd2048, 14'sd0);
    repeat (2) @(negedge clk);
    total++;
    if ({Re_o0, Im_o0, Re_o1, Im_o1} !== {29'(9), 29'(10), 29'(11), 29'(10)}) begin
      bad++;
      $display("FAIL floor_data got (%0d,%0d) (%0d,%0d) want (9,10) (11,10)",
               Re_o0, Im_o0, Re_o1, Im_o1);
    end
    total++;
    if ({out_valid, bfly_idx} !== {1'b1, 3'd2}) begin
      bad++;
      $display("FAIL floor_ctrl got v=%b idx=%0d want v=1 idx=2", out_valid, bfly_idx);
    end
  endtask

  // 16 back-to-back samples; pair i is A=(10i,i), B=(i,-i), W=1 -> X0=(11i,0), X1=(9i,2i).
  // B of pair i is accepted on edge 2i+1, so its result is seen at falling edge 2i+4.
  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    do_clr();
    for (int c = 0; c <= 20; c++) begin
      if (c >= 4 && c <= 18 && (c % 2) == 0) begin
        int i;
        i = (c - 4) / 2;
        pulses++;
        total++;
        if ({out_valid, bfly_idx, stage_done} !== {1'b1, 3'(i), (i == 7)}) begin
          bad++;
          $display("FAIL b2b_ctrl c=%0d got v=%b idx=%0d sd=%b want v=1 idx=%0d sd=%b", c,
                   out_valid, bfly_idx, stage_done, i, (i == 7));
        end
        total++;
        if ({Re_o0, Im_o0, Re_o1, Im_o1} !==
            {29'(11 * i), 29'(0), 29'(9 * i), 29'(2 * i)}) begin
          bad++;
          $display("FAIL b2b_data i=%0d got (%0d,%0d) (%0d,%0d) want (%0d,0) (%0d,%0d)", i,
                   Re_o0, Im_o0, Re_o1, Im_o1, 11 * i, 9 * i, 2 * i);
        end
      end else begin
        total++;
        if (out_valid !== 1'b0 || stage_done !== 1'b0) begin
          bad++;
          $display("FAIL b2b_idle c=%0d got v=%b sd=%b want 0 0", c, out_valid, stage_done);
        end
      end
      if (c < 16) begin
        en_radix = 1'b1;
        Re_i = (c % 2 == 0) ? 29'(10 * (c / 2)) : 29'(c / 2);
        Im_i = (c % 2 == 0) ? 29'(c / 2) : -29'(c / 2);
        cos_data = 14'sd4096;
        sin_data = 14'sd0;
      end else begin
        en_radix = 1'b0;
      end
      @(negedge clk);
    end
    total++;
    if (pulses != 8) begin
      bad++;
      $display("FAIL b2b_count got %0d want 8", pulses);
    end
    send(29'(5), 29'(5), 14'sd0, 14'sd0);
    send(29'(1), 29'(1), 14'sd4096, 14'sd0);
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, bfly_idx, stage_done, Re_o0, Im_o1} !==
        {1'b1, 3'd0, 1'b0, 29'(6), 29'(4)}) begin
      bad++;
      $display("FAIL b2b_wrap got v=%b idx=%0d sd=%b re0=%0d im1=%0d want 1 0 0 6 4",
               out_valid, bfly_idx, stage_done, Re_o0, Im_o1);
    end
  endtask

  task automatic test_gap_and_clr();
    do_clr();
    send(29'(100), 29'(50), 14'sd0, 14'sd0);
    repeat (5) @(negedge clk);
    send(29'(30), -29'(20), 14'sd4096, 14'sd0);
    repeat (2) @(negedge clk);
    total++;
    if ({Re_o0, Im_o0, Re_o1, Im_o1, out_valid, bfly_idx} !==
        {29'(130), 29'(30), 29'(70), 29'(70), 1'b1, 3'd0}) begin
      bad++;
      $display("FAIL gap_data got (%0d,%0d) (%0d,%0d) v=%b idx=%0d want (130,30) (70,70) 1 0",
               Re_o0, Im_o0, Re_o1, Im_o1, out_valid, bfly_idx);
    end
    // clr one cycle after B kills that butterfly
    send(29'(40), 29'(40), 14'sd0, 14'sd0);
    send(29'(1), 29'(1), 14'sd4096, 14'sd0);
    do_clr();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL clr_kill k=%0d got v=%b want 0", k, out_valid);
      end
      @(negedge clk);
    end
    total++;
    if ({Re_o0, Im_o0, Re_o1, Im_o1} !== {29'(130), 29'(30), 29'(70), 29'(70)}) begin
      bad++;
      $display("FAIL clr_hold got (%0d,%0d) (%0d,%0d) want (130,30) (70,70)",
               Re_o0, Im_o0, Re_o1, Im_o1);
    end
    // A lone A followed by clr must be forgotten
    send(29'(7), 29'(7), 14'sd0, 14'sd0);
    do_clr();
    send(29'(1), 29'(2), 14'sd0, 14'sd0);
    send(29'(3), 29'(4), 14'sd4096, 14'sd0);
    repeat (2) @(negedge clk);
    total++;
    if ({Re_o0, Im_o0, Re_o1, Im_o1, out_valid, bfly_idx} !==
        {29'(4), 29'(6), -29'(2), -29'(2), 1'b1, 3'd0}) begin
      bad++;
      $display("FAIL clr_fresh got (%0d,%0d) (%0d,%0d) v=%b idx=%0d want (4,6) (-2,-2) 1 0",
               Re_o0, Im_o0, Re_o1, Im_o1, out_valid, bfly_idx);
    end
  endtask

  task automatic test_overflow();
    logic signed [28:0] m;
    m = 29'(268435455);  // 2^28 - 1
    do_clr();
    total++;
    if (ovf !== 1'b0 || ovf_s !== 1'b0) begin
      bad++;
      $display("FAIL ovf_pre got %b/%b want 0/0", ovf, ovf_s);
    end
    send(m, 29'(0), 14'sd0, 14'sd0);
    send(m, 29'(0), 14'sd4096, 14'sd0);
    repeat (2) @(negedge clk);
    total++;
    if (ovf !== 1'b1 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set got ovf=%b v=%b want 1 1", ovf, out_valid);
    end
    total++;
    if ({re0_s, im0_s, re1_s, im1_s, ovf_s} !== {m, 29'(0), 29'(0), 29'(0), 1'b0}) begin
      bad++;
      $display("FAIL ovf_scaled got (%0d,%0d) (%0d,%0d) ovf=%b want (%0d,0) (0,0) 0",
               re0_s, im0_s, re1_s, im1_s, ovf_s, m);
    end
    send(29'(1), 29'(0), 14'sd0, 14'sd0);
    send(29'(1), 29'(0), 14'sd4096, 14'sd0);
    repeat (2) @(negedge clk);
    total++;
    if (ovf !== 1'b1 || Re_o0 !== 29'(2)) begin
      bad++;
      $display("FAIL ovf_sticky got ovf=%b re0=%0d want 1 2", ovf, Re_o0);
    end
    do_clr();
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clr got %b want 0", ovf);
    end
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    en_radix = 1'b0;
    Re_i = '0;
    Im_i = '0;
    cos_data = '0;
    sin_data = '0;
    test_reset();
    test_w_one();
    test_w_minus_j();
    test_floor();
    test_back_to_back();
    test_gap_and_clr();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
